// File: rtl/axi4_lite_slave_pkg.sv
// Shared AXI4-Lite bus widths and the state encodings of the slave's
// write and read channel FSMs.
package axi4_lite_Defs;

   localparam int Addr_Width = 32;
   localparam int Data_Width = 32;

   typedef enum logic [1:0] {
      W_IDLE,
      W_WAIT_DATA,
      W_WAIT_ADDR,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

endpackage

// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite bus bundle (no response codes) with master and slave views.
interface axi4_lite_slave_if;
   import axi4_lite_Defs::*;

   logic [Addr_Width-1:0] AWADDR;
   logic                  AWVALID;
   logic                  AWREADY;
   logic [Data_Width-1:0] WDATA;
   logic                  WVALID;
   logic                  WREADY;
   logic                  BVALID;
   logic                  BREADY;
   logic [Addr_Width-1:0] ARADDR;
   logic                  ARVALID;
   logic                  ARREADY;
   logic [Data_Width-1:0] RDATA;
   logic                  RVALID;
   logic                  RREADY;

   modport master_if (
      output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BVALID, ARREADY, RDATA, RVALID
   );

   modport slave_if (
      input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BVALID, ARREADY, RDATA, RVALID
   );

endinterface

// File: rtl/axi4_lite_slave_regmem.sv
// Word memory with one write port and one registered read port; a read and a
// write to the same word on one edge return the old contents.
module axi4_lite_regmem
   import axi4_lite_Defs::*;
#(
   parameter  int Mem_Depth = 256,
   localparam int Idx_W     = $clog2(Mem_Depth)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [Idx_W-1:0]      waddr,
   input  logic [Data_Width-1:0] wdata,
   input  logic                  re,
   input  logic [Idx_W-1:0]      raddr,
   output logic [Data_Width-1:0] rdata
);

   logic [Data_Width-1:0] mem [Mem_Depth];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < Mem_Depth; i++) mem[i] <= '0;
         rdata <= '0;
      end else begin
         if (we) mem[waddr] <= wdata;
         // rdata is left untouched when idle so the last read stays visible
         if (re) rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave: independent write and read FSMs in front of a word memory.
// All bus outputs are registered; upper address bits alias onto the memory.
module axi4_lite_slave
   import axi4_lite_Defs::*;
#(
   parameter int Mem_Depth = 256
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   axi4_lite_slave_if.slave_if bus
);

   localparam int Idx_W = $clog2(Mem_Depth);

   function automatic logic [Idx_W-1:0] idx_of(input logic [Addr_Width-1:0] a);
      return a[Idx_W+1:2];
   endfunction

   wr_state_t             wr_q, wr_d;
   rd_state_t             rd_q, rd_d;
   logic [Idx_W-1:0]      addr_lat_q, addr_lat_d;
   logic [Data_Width-1:0] data_lat_q, data_lat_d;
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic                  arready_q, arready_d;
   logic                  rvalid_q, rvalid_d;

   logic                  mem_we, mem_re;
   logic [Idx_W-1:0]      mem_widx, mem_ridx;
   logic [Data_Width-1:0] mem_wdata, mem_rdata;

   logic aw_hs, w_hs, ar_hs;
   assign aw_hs = bus.AWVALID && awready_q;
   assign w_hs  = bus.WVALID  && wready_q;
   assign ar_hs = bus.ARVALID && arready_q;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_q       <= W_IDLE;
         rd_q       <= R_IDLE;
         addr_lat_q <= '0;
         data_lat_q <= '0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
      end else begin
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         addr_lat_q <= addr_lat_d;
         data_lat_q <= data_lat_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
      end
   end

   always_comb begin
      wr_d       = wr_q;
      addr_lat_d = addr_lat_q;
      data_lat_d = data_lat_q;
      mem_we     = 1'b0;
      mem_widx   = '0;
      mem_wdata  = '0;
      case (wr_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               mem_we    = 1'b1;
               mem_widx  = idx_of(bus.AWADDR);
               mem_wdata = bus.WDATA;
               wr_d      = W_RESP;
            end else if (aw_hs) begin
               addr_lat_d = idx_of(bus.AWADDR);
               wr_d       = W_WAIT_DATA;
            end else if (w_hs) begin
               data_lat_d = bus.WDATA;
               wr_d       = W_WAIT_ADDR;
            end
         end
         W_WAIT_DATA: begin
            if (w_hs) begin
               mem_we    = 1'b1;
               mem_widx  = addr_lat_q;
               mem_wdata = bus.WDATA;
               wr_d      = W_RESP;
            end
         end
         W_WAIT_ADDR: begin
            if (aw_hs) begin
               mem_we    = 1'b1;
               mem_widx  = idx_of(bus.AWADDR);
               mem_wdata = data_lat_q;
               wr_d      = W_RESP;
            end
         end
         W_RESP: begin
            if (bus.BREADY) wr_d = W_IDLE;
         end
         default: wr_d = W_IDLE;
      endcase
      // Outputs are decoded from the next state so they register as Moore outputs
      awready_d = (wr_d == W_IDLE) || (wr_d == W_WAIT_ADDR);
      wready_d  = (wr_d == W_IDLE) || (wr_d == W_WAIT_DATA);
      bvalid_d  = (wr_d == W_RESP);
   end

   always_comb begin
      rd_d     = rd_q;
      mem_re   = 1'b0;
      mem_ridx = '0;
      case (rd_q)
         R_IDLE: begin
            if (ar_hs) begin
               mem_re   = 1'b1;
               mem_ridx = idx_of(bus.ARADDR);
               rd_d     = R_DATA;
            end
         end
         R_DATA: begin
            if (bus.RREADY) rd_d = R_IDLE;
         end
         default: rd_d = R_IDLE;
      endcase
      arready_d = (rd_d == R_IDLE);
      rvalid_d  = (rd_d == R_DATA);
   end

   axi4_lite_regmem #(.Mem_Depth(Mem_Depth)) u_regmem (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .we    (mem_we),
      .waddr (mem_widx),
      .wdata (mem_wdata),
      .re    (mem_re),
      .raddr (mem_ridx),
      .rdata (mem_rdata)
   );

   assign bus.AWREADY = awready_q;
   assign bus.WREADY  = wready_q;
   assign bus.BVALID  = bvalid_q;
   assign bus.ARREADY = arready_q;
   assign bus.RVALID  = rvalid_q;
   assign bus.RDATA   = mem_rdata;

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Directed and randomized bench for axi4_lite_slave against an array model
// of the word memory (index = (addr / 4) mod depth).
module tb_axi4_lite_slave;
   import axi4_lite_Defs::*;

   localparam int Depth = 256;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axi4_lite_slave_if bus();

   axi4_lite_slave #(.Mem_Depth(Depth)) dut (
      .ACLK    (clk),
      .ARESETN (rst_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] model [Depth];

   function automatic int midx(input logic [31:0] a);
      return int'((a >> 2) % Depth);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs(input string tag, input logic rdy, input logic [31:0] rdata);
      chk1({tag, "_awready"}, bus.AWREADY, rdy);
      chk1({tag, "_wready"},  bus.WREADY,  rdy);
      chk1({tag, "_arready"}, bus.ARREADY, rdy);
      chk1({tag, "_bvalid"},  bus.BVALID,  1'b0);
      chk1({tag, "_rvalid"},  bus.RVALID,  1'b0);
      chk({tag, "_rdata"},    bus.RDATA,   rdata);
   endtask

   // Master-side rule: a raised VALID keeps its payload until READY
   logic        pv_aw = 1'b0, pv_w = 1'b0, pv_ar = 1'b0;
   logic [31:0] pa_aw, pd_w, pa_ar;
   always @(posedge clk) begin
      if (rst_n && pv_aw) assert (bus.AWVALID && bus.AWADDR == pa_aw)
         else $error("AWVALID or AWADDR changed before AWREADY");
      if (rst_n && pv_w) assert (bus.WVALID && bus.WDATA == pd_w)
         else $error("WVALID or WDATA changed before WREADY");
      if (rst_n && pv_ar) assert (bus.ARVALID && bus.ARADDR == pa_ar)
         else $error("ARVALID or ARADDR changed before ARREADY");
      pv_aw <= bus.AWVALID && !bus.AWREADY;
      pv_w  <= bus.WVALID  && !bus.WREADY;
      pv_ar <= bus.ARVALID && !bus.ARREADY;
      pa_aw <= bus.AWADDR;
      pd_w  <= bus.WDATA;
      pa_ar <= bus.ARADDR;
   end

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input int aw_dly, input int w_dly, input int b_dly);
      bit aw_done, w_done;
      int cyc;
      aw_done = 0; w_done = 0; cyc = 0;
      bus.AWADDR = a;
      bus.WDATA  = d;
      while (!(aw_done && w_done) && cyc < 40) begin
         if (w_done && !aw_done) begin
            chk1("wready_drop", bus.WREADY, 1'b0);
            chk1("awready_wait", bus.AWREADY, 1'b1);
         end
         if (aw_done && !w_done) begin
            chk1("awready_drop", bus.AWREADY, 1'b0);
            chk1("wready_wait", bus.WREADY, 1'b1);
         end
         bus.AWVALID = !aw_done && (cyc >= aw_dly);
         bus.WVALID  = !w_done && (cyc >= w_dly);
         if (bus.AWVALID && bus.AWREADY) aw_done = 1;
         if (bus.WVALID && bus.WREADY) w_done = 1;
         @(negedge clk);
         cyc++;
      end
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      chk1("wr_hs_done", aw_done && w_done, 1'b1);
      model[midx(a)] = d;
      chk1("bvalid_rise", bus.BVALID, 1'b1);
      for (int i = 0; i < b_dly; i++) begin
         @(negedge clk);
         chk1("bvalid_hold", bus.BVALID, 1'b1);
         chk("wr_rdy_low", {30'b0, bus.AWREADY, bus.WREADY}, 32'd0);
      end
      bus.BREADY = 1'b1;
      @(negedge clk);
      bus.BREADY = 1'b0;
      chk1("bvalid_fall", bus.BVALID, 1'b0);
      chk("wr_rdy_back", {30'b0, bus.AWREADY, bus.WREADY}, 32'd3);
   endtask

   task automatic do_read(input logic [31:0] a, input int ar_dly, input int r_dly);
      logic [31:0] exp;
      bit done;
      int cyc;
      exp = model[midx(a)];
      done = 0; cyc = 0;
      bus.ARADDR = a;
      while (!done && cyc < 40) begin
         bus.ARVALID = (cyc >= ar_dly);
         if (bus.ARVALID && bus.ARREADY) done = 1;
         @(negedge clk);
         cyc++;
      end
      bus.ARVALID = 1'b0;
      chk1("rd_hs_done", done, 1'b1);
      chk1("rvalid_rise", bus.RVALID, 1'b1);
      chk1("arready_low", bus.ARREADY, 1'b0);
      chk("rdata", bus.RDATA, exp);
      for (int i = 0; i < r_dly; i++) begin
         @(negedge clk);
         chk1("rvalid_hold", bus.RVALID, 1'b1);
         chk1("arready_hold_low", bus.ARREADY, 1'b0);
         chk("rdata_stable", bus.RDATA, exp);
      end
      bus.RREADY = 1'b1;
      @(negedge clk);
      bus.RREADY = 1'b0;
      chk1("rvalid_fall", bus.RVALID, 1'b0);
      chk1("arready_back", bus.ARREADY, 1'b1);
      chk("rdata_keep", bus.RDATA, exp);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired before the bench completed");
      $fatal(1);
   end

   initial begin
      logic [31:0] a, d;
      for (int i = 0; i < Depth; i++) model[i] = '0;
      bus.AWADDR = '0; bus.AWVALID = 1'b0;
      bus.WDATA  = '0; bus.WVALID  = 1'b0;
      bus.BREADY = 1'b0;
      bus.ARADDR = '0; bus.ARVALID = 1'b0;
      bus.RREADY = 1'b0;

      // reset held for three cycles, then released
      repeat (3) begin
         @(negedge clk);
         chk_outputs("in_reset", 1'b0, 32'd0);
      end
      rst_n = 1'b1;
      #1;
      chk_outputs("release_no_edge", 1'b0, 32'd0);
      @(negedge clk);
      chk_outputs("after_release", 1'b1, 32'd0);

      // aligned write and read-back
      do_write(32'h10, 32'hDEADBEEF, 0, 0, 0);
      do_read(32'h10, 0, 0);

      // W three cycles ahead of AW, then AW ahead of W
      do_write(32'h20, 32'h12345678, 3, 0, 0);
      do_read(32'h20, 0, 0);
      do_write(32'h24, 32'hCAFEF00D, 0, 2, 0);
      do_read(32'h24, 0, 0);

      // response backpressure
      do_write(32'h28, 32'h0BADF00D, 0, 0, 5);
      do_read(32'h28, 0, 4);

      // collision: commit and AR capture on one edge to the same word
      do_write(32'h10, 32'hAAAA0000, 0, 0, 0);
      bus.AWADDR = 32'h10; bus.WDATA = 32'h5555FFFF; bus.ARADDR = 32'h10;
      bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
      @(negedge clk);
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
      chk1("coll_bvalid", bus.BVALID, 1'b1);
      chk1("coll_rvalid", bus.RVALID, 1'b1);
      chk("coll_old_word", bus.RDATA, 32'hAAAA0000);
      model[midx(32'h10)] = 32'h5555FFFF;
      bus.BREADY = 1'b1; bus.RREADY = 1'b1;
      @(negedge clk);
      bus.BREADY = 1'b0; bus.RREADY = 1'b0;
      chk1("coll_done_b", bus.BVALID, 1'b0);
      chk1("coll_done_r", bus.RVALID, 1'b0);
      do_read(32'h10, 0, 0);
      chk("alias_idx", midx(32'h410), 32'd4);
      do_read(32'h410, 0, 0);
      do_write(32'h413, 32'h600DD00D, 1, 0, 1);
      do_read(32'h10, 1, 0);

      // reset while only the write address is held
      bus.AWADDR = 32'h30; bus.AWVALID = 1'b1;
      @(negedge clk);
      bus.AWVALID = 1'b0;
      chk1("half_aw_awready", bus.AWREADY, 1'b0);
      chk1("half_aw_wready", bus.WREADY, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk_outputs("async_reset", 1'b0, 32'd0);
      for (int i = 0; i < Depth; i++) model[i] = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_outputs("after_rereset", 1'b1, 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk1("no_stale_bvalid", bus.BVALID, 1'b0);
      end
      do_read(32'h30, 0, 0);
      do_read(32'h10, 0, 0);

      // randomized traffic on a small set of words with random upper bits
      for (int n = 0; n < 60; n++) begin
         a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
         d = $urandom;
         if ($urandom_range(0, 1) == 1)
            do_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            do_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
